// File: rtl/neopixel_driver.sv
// neopixel_driver: WS2812 serialiser with a NUM_PIXELS x GRB colour store and producer handshakes
module neopixel_driver #(
    parameter int NUM_PIXELS = 5,
    parameter int T0H        = 18,
    parameter int T1H        = 35,
    parameter int BIT_PERIOD = 63,
    parameter int T_RESET    = 2500
) (
    input  logic       clock,
    input  logic       reset_L,
    input  logic [2:0] pixel_index,
    input  logic [1:0] color_index,
    input  logic [7:0] color_level,
    input  logic       load_color,
    input  logic       send_it,
    output logic       neo_data,
    output logic       ready_to_load,
    output logic       ready_to_send,
    output logic       begin_send,
    output logic       done_send,
    output logic       done_wait
);
    localparam int TW = $clog2(BIT_PERIOD);
    localparam int PW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int WW = $clog2(T_RESET);
    localparam logic [1:0] IDLE = 2'd0, SEND = 2'd1, WAIT = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [4:0]    bit_q, bit_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [7:0]    store_q [NUM_PIXELS][3];
    logic [7:0]    store_d [NUM_PIXELS][3];
    logic [7:0]    cur_byte;
    logic          bit_val, bit_end, last_bit, wr_en;

    always_comb begin
        // bit_q[4:3] picks G/R/B, bit_q[2:0] counts from the MSB down
        cur_byte = store_q[pix_q][bit_q[4:3]];
        bit_val  = cur_byte[~bit_q[2:0]];
        bit_end  = timer_q == TW'(BIT_PERIOD - 1);
        last_bit = bit_end && bit_q == 5'd23 && pix_q == PW'(NUM_PIXELS - 1);
        wr_en    = state_q == IDLE && load_color && int'(pixel_index) < NUM_PIXELS && color_index != 2'd3;
        store_d  = store_q;
        if (wr_en)
            store_d[pixel_index][color_index] = color_level;
        state_d = state_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        pix_d   = pix_q;
        wait_d  = wait_q;
        if (state_q == IDLE && send_it) begin
            state_d = SEND;
            timer_d = '0;
            bit_d   = '0;
            pix_d   = '0;
        end
        if (state_q == SEND) begin
            timer_d = bit_end ? '0 : timer_q + 1'b1;
            bit_d   = !bit_end ? bit_q : (bit_q == 5'd23) ? 5'd0 : bit_q + 1'b1;
            pix_d   = (bit_end && bit_q == 5'd23) ? pix_q + 1'b1 : pix_q;
            if (last_bit) begin
                state_d = WAIT;
                wait_d  = '0;
                pix_d   = '0;
            end
        end
        if (state_q == WAIT) begin
            wait_d  = wait_q + 1'b1;
            state_d = done_wait ? IDLE : WAIT;
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            pix_q   <= '0;
            wait_q  <= '0;
            store_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            pix_q   <= pix_d;
            wait_q  <= wait_d;
            store_q <= store_d;
        end
    end

    assign neo_data      = state_q == SEND && timer_q < (bit_val ? TW'(T1H) : TW'(T0H));
    assign ready_to_load = state_q == IDLE;
    assign ready_to_send = state_q == IDLE;
    assign begin_send    = state_q == SEND && timer_q == '0 && bit_q == '0 && pix_q == '0;
    assign done_send     = state_q == SEND && last_bit;
    assign done_wait     = state_q == WAIT && wait_q == WW'(T_RESET - 1);
endmodule

// File: tb/tb_neopixel_driver.sv
// tb_neopixel_driver: directed frame captures of the WS2812 driver against hand-built bit vectors
module tb_neopixel_driver;
    logic       clock = 1'b0;
    logic       reset_L = 1'b0;
    logic [2:0] pixel_index = '0;
    logic [1:0] color_index = '0;
    logic [7:0] color_level = '0;
    logic       load_color = 1'b0;
    logic       send_it = 1'b0;
    logic       neo_data, ready_to_load, ready_to_send, begin_send, done_send, done_wait;
    int         vectors = 0;
    int         miscompares = 0;
    logic [119:0] frame, exp2, exp3;

    neopixel_driver dut (
        .clock(clock), .reset_L(reset_L), .pixel_index(pixel_index), .color_index(color_index),
        .color_level(color_level), .load_color(load_color), .send_it(send_it), .neo_data(neo_data),
        .ready_to_load(ready_to_load), .ready_to_send(ready_to_send), .begin_send(begin_send),
        .done_send(done_send), .done_wait(done_wait)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [119:0] obs, input logic [119:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [2:0] p, input logic [1:0] c, input logic [7:0] l, input logic s);
        pixel_index = p;
        color_index = c;
        color_level = l;
        load_color  = 1'b1;
        send_it     = s;
        step();
        load_color  = 1'b0;
        send_it     = 1'b0;
    endtask

    task automatic poke(input int c);
        pixel_index = 3'(c % 5);
        color_index = 2'(c % 3);
        color_level = 8'(c) ^ 8'hA5;
        load_color  = 1'b1;
        send_it     = 1'b1;
    endtask

    // Entered in frame cycle 1; returns in the first IDLE cycle after the latch time.
    task automatic run_frame(input bit disturb, output logic [119:0] bits);
        int bad, bs_n, bs_at, ds_n, ds_at, dw_n, dw_at, c, hi;
        bit low_seen;
        bad = 0; bs_n = 0; bs_at = 0; ds_n = 0; ds_at = 0; dw_n = 0; dw_at = 0; c = 0;
        bits = '0;
        for (int b = 0; b < 120; b++) begin
            hi = 0;
            low_seen = 1'b0;
            for (int t = 0; t < 63; t++) begin
                c++;
                if (neo_data) begin
                    hi++;
                    if (low_seen) bad++;
                end else low_seen = 1'b1;
                if (begin_send) begin bs_n++; bs_at = c; end
                if (done_send) begin ds_n++; ds_at = c; end
                if (ready_to_load || ready_to_send || done_wait) bad++;
                if (disturb) poke(c);
                step();
            end
            bits[b] = (hi == 35);
            if (hi != 35 && hi != 18) bad++;
        end
        for (int w = 1; w <= 2500; w++) begin
            if (neo_data || ready_to_load || ready_to_send || begin_send || done_send) bad++;
            if (done_wait) begin dw_n++; dw_at = w; end
            if (disturb && w < 2500) poke(w);
            else begin load_color = 1'b0; send_it = 1'b0; end
            step();
        end
        chk("begin_send_count", 120'(bs_n), 120'd1);
        chk("begin_send_cycle", 120'(bs_at), 120'd1);
        chk("done_send_count", 120'(ds_n), 120'd1);
        chk("done_send_cycle", 120'(ds_at), 120'd7560);
        chk("done_wait_count", 120'(dw_n), 120'd1);
        chk("done_wait_cycle", 120'(dw_at), 120'd2500);
        chk("frame_shape_errors", 120'(bad), 120'd0);
        chk("idle_ready_after_frame", 120'({ready_to_load, ready_to_send, neo_data}), 120'b110);
    endtask

    initial begin
        int bad;
        repeat (3) step();
        chk("reset_outputs", 120'({neo_data, begin_send, done_send, done_wait}), 120'b0000);
        reset_L = 1'b1;
        step();
        chk("reset_release_ready", 120'({ready_to_load, ready_to_send, neo_data}), 120'b110);

        // empty store: all '0' bits
        send_it = 1'b1;
        step();
        send_it = 1'b0;
        run_frame(1'b0, frame);
        chk("frame_empty", frame, 120'd0);

        // p0 G MSB and p4 B LSB set
        load(3'd0, 2'd0, 8'h80, 1'b0);
        load(3'd4, 2'd2, 8'h01, 1'b0);
        send_it = 1'b1;
        step();
        send_it = 1'b0;
        exp2 = (120'd1) | (120'd1 << 119);
        run_frame(1'b0, frame);
        chk("frame_p0g_p4b", frame, exp2);

        // write and send in the same cycle: p2 R = FF lands in bits 56..63
        load(3'd2, 2'd1, 8'hFF, 1'b1);
        exp3 = exp2 | (120'hFF << 56);
        run_frame(1'b0, frame);
        chk("frame_load_and_send", frame, exp3);

        // dropped writes in IDLE, then writes/sends hammered during SEND and WAIT
        load(3'd5, 2'd0, 8'hAA, 1'b0);
        load(3'd1, 2'd3, 8'h55, 1'b0);
        send_it = 1'b1;
        step();
        send_it = 1'b0;
        run_frame(1'b1, frame);
        chk("frame_disturbed", frame, exp3);

        // back-to-back: send on the first IDLE cycle after done_wait
        send_it = 1'b1;
        step();
        send_it = 1'b0;
        run_frame(1'b0, frame);
        chk("frame_back_to_back", frame, exp3);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (neo_data || begin_send || !ready_to_send) bad++;
            step();
        end
        chk("no_restart_idle", 120'(bad), 120'd0);

        // reset mid-frame at bit 40
        send_it = 1'b1;
        step();
        send_it = 1'b0;
        bad = 0;
        for (int i = 1; i < 40 * 63 + 5; i++) begin
            if (done_send || done_wait) bad++;
            step();
        end
        chk("mid_frame_high", 120'(neo_data), 120'd1);
        #2 reset_L = 1'b0;
        #1;
        chk("reset_async_low", 120'({neo_data, done_send, done_wait}), 120'b000);
        step();
        step();
        reset_L = 1'b1;
        step();
        chk("ready_after_abort", 120'({ready_to_load, ready_to_send}), 120'b11);
        for (int i = 0; i < 5; i++) begin
            if (done_send || done_wait || neo_data) bad++;
            step();
        end
        chk("no_done_after_abort", 120'(bad), 120'd0);
        send_it = 1'b1;
        step();
        send_it = 1'b0;
        run_frame(1'b0, frame);
        chk("frame_store_cleared", frame, 120'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
